cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of functional units sharing the common data bus (CDB).
REQ-002 The block SHALL have parameter ROB_WIDTH, default 4, the ROB tag width, matching the package value.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: unit i has a result to broadcast.
REQ-006 The block SHALL have port req_tag, input, N_REQ x ROB_WIDTH: the ROB tag of unit i's result.
REQ-007 The block SHALL have port req_data, input, N_REQ x 32: the result data of unit i.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: a one-hot-or-zero grant to unit i.
REQ-009 The block SHALL have port flush, input, 1 bit: mispredict recovery that discards the current arbitration.
REQ-010 The block SHALL have port cdb_valid, output, 1 bit: the broadcast is valid.
REQ-011 The block SHALL have port cdb_tag, output, ROB_WIDTH: the broadcast tag.
REQ-012 The block SHALL have port cdb_data, output, 32 bits: the broadcast data.

Function
REQ-013 The block SHALL hold an internal round-robin pointer rr_ptr, width clog2(N_REQ), range 0..N_REQ-1.
REQ-014 req_ready SHALL be combinational: assert bit g only, where g is the first index with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-015 req_ready SHALL be all-zero when no req_valid bit is high, when flush=1, or when reset=1.
REQ-016 A transfer SHALL occur for unit i when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-017 A requester SHALL hold req_valid, req_tag and req_data stable until its transfer; the block SHALL NOT require req_valid to drop after a transfer.
REQ-018 On a transfer from unit g, on the following cycle the block SHALL drive cdb_valid=1, cdb_tag=req_tag[g] and cdb_data=req_data[g], giving 1-cycle latency from grant to broadcast.
REQ-019 On a transfer from unit g, rr_ptr SHALL become (g+1) mod N_REQ.
REQ-020 On a cycle with no transfer, cdb_valid SHALL be 0 on the next cycle, cdb_tag and cdb_data SHALL hold their previous values, and rr_ptr SHALL be unchanged.
REQ-021 On a flush cycle, no transfer SHALL occur, cdb_valid SHALL be 0 on the next cycle, and rr_ptr SHALL be unchanged.
REQ-022 A flush SHALL NOT cancel the broadcast already registered from the previous cycle; it remains visible during the flush cycle.
REQ-023 At most one transfer SHALL occur per cycle, and the CDB SHALL carry at most one result per cycle.
REQ-024 Fairness: a requester holding req_valid continuously SHALL be granted within N_REQ cycles that are free of flush.
REQ-025 Wrap-around: with rr_ptr=N_REQ-1 and only unit 0 valid, unit 0 SHALL be granted and rr_ptr SHALL become 1.
REQ-026 A single continuously valid requester SHALL be granted every cycle, sustaining back-to-back cdb_valid.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL set cdb_valid=0, cdb_tag=0, cdb_data=0 and rr_ptr=0.
REQ-028 reset SHALL take priority over flush and over any pending request; a request held across reset SHALL be re-arbitrated from rr_ptr=0 after reset deasserts.
REQ-029 After reset the first grant SHALL be available in the first cycle with reset=0.

Verification
REQ-030 Reset, then all four units valid with tags 1,2,3,4 and data 0x10,0x20,0x30,0x40 held -> grants go to 0,1,2,3,0 on consecutive cycles, and the CDB shows (1,0x10),(2,0x20),(3,0x30),(4,0x40) one cycle after each grant.
REQ-031 Only unit 2 valid with tag 5 and data 0xDEADBEEF for 3 cycles -> req_ready[2]=1 every cycle, and cdb_valid=1 for 3 consecutive cycles with tag 5 and data 0xDEADBEEF.
REQ-032 Grant unit 3 (rr_ptr becomes 0), then only unit 0 valid -> unit 0 is granted; then with units 0 and 1 valid, unit 1 is granted first.
REQ-033 Units 1 and 2 valid and flush=1 for one cycle -> req_ready=0, cdb_valid=0 the next cycle, rr_ptr unchanged; unit 1 is granted the cycle after the flush.
REQ-034 reset asserted while unit 1 is valid and a broadcast of tag 7 is registered -> the next cycle shows cdb_valid=0, cdb_tag=0, cdb_data=0; after release, with units 1 and 3 valid, unit 1 is granted.
REQ-035 No valid requests for 5 cycles after a broadcast of tag 9 and data 0x1234 -> cdb_valid=0 on all 5 cycles, cdb_tag stays 9, cdb_data stays 0x1234, and no req_ready bit asserts.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving one registered common data bus broadcast per cycle
module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ROB_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ROB_WIDTH-1:0]   req_tag,
  input  logic [N_REQ*32-1:0]          req_data,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         flush,
  output logic                         cdb_valid,
  output logic [ROB_WIDTH-1:0]         cdb_tag,
  output logic [31:0]                  cdb_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]     rr_ptr;
  logic [N_REQ-1:0]     grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [ROB_WIDTH-1:0] sel_tag;
  logic [31:0]          sel_data;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        grant_any  = 1'b1;
      end
    end
    if (reset || flush) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_tag  = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  // Tag and data hold their last broadcast when the bus goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= sel_tag;
      cdb_data  <= sel_data;
      rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and random checks of cdb_arbiter against a round-robin reference model
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_tag;
  logic [N*32-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           flush;
  logic           cdb_valid;
  logic [W-1:0]   cdb_tag;
  logic [31:0]    cdb_data;

  cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_tag(req_tag),
    .req_data(req_data),
    .req_ready(req_ready),
    .flush(flush),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [W-1:0]  tg [N];
  logic [31:0]   dt [N];

  int            m_ptr;
  logic          m_valid;
  logic [W-1:0]  m_tag;
  logic [31:0]   m_data;

  task automatic check1(input string name, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check grant, clock, check the bus.
  task automatic do_cycle(input string name, input logic rst, input logic fl, input logic [N-1:0] v);
    logic [N-1:0] exp_grant;
    int g;
    reset = rst;
    flush = fl;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_tag[i*W +: W]   = tg[i];
      req_data[i*32 +: 32] = dt[i];
    end
    exp_grant = '0;
    g = -1;
    if (!rst && !fl) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) exp_grant[g] = 1'b1;
    end
    #1;
    checkv({name, ".req_ready"}, 32'(req_ready), 32'(exp_grant));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_tag   = '0;
      m_data  = '0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_tag   = tg[g];
      m_data  = dt[g];
      m_ptr   = (g + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check1({name, ".cdb_valid"}, cdb_valid, m_valid);
    checkv({name, ".cdb_tag"}, 32'(cdb_tag), 32'(m_tag));
    checkv({name, ".cdb_data"}, cdb_data, m_data);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;
    m_ptr = 0;
    m_valid = 1'b0;
    m_tag = '0;
    m_data = '0;
    for (int i = 0; i < N; i++) begin
      tg[i] = '0;
      dt[i] = '0;
    end
    @(negedge clk);

    do_cycle("reset0", 1'b1, 1'b0, 4'b0000);
    do_cycle("reset1", 1'b1, 1'b0, 4'b1111);

    for (int i = 0; i < N; i++) begin
      tg[i] = W'(i + 1);
      dt[i] = 32'((i + 1) * 16);
    end
    for (int c = 0; c < 5; c++) do_cycle("all_valid", 1'b0, 1'b0, 4'b1111);

    tg[2] = 4'd5;
    dt[2] = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) do_cycle("single_u2", 1'b0, 1'b0, 4'b0100);

    do_cycle("grant_u3", 1'b0, 1'b0, 4'b1000);
    do_cycle("wrap_u0", 1'b0, 1'b0, 4'b0001);
    do_cycle("after_wrap", 1'b0, 1'b0, 4'b0011);

    do_cycle("pre_flush", 1'b0, 1'b0, 4'b0001);
    do_cycle("flush", 1'b0, 1'b1, 4'b0110);
    do_cycle("post_flush", 1'b0, 1'b0, 4'b0110);

    tg[1] = 4'd7;
    do_cycle("tag7", 1'b0, 1'b0, 4'b0010);
    do_cycle("reset_mid", 1'b1, 1'b0, 4'b0010);
    do_cycle("post_reset", 1'b0, 1'b0, 4'b1010);

    tg[0] = 4'd9;
    dt[0] = 32'h1234;
    do_cycle("tag9", 1'b0, 1'b0, 4'b0001);
    for (int c = 0; c < 5; c++) do_cycle("idle", 1'b0, 1'b0, 4'b0000);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        tg[i] = W'($urandom);
        dt[i] = $urandom;
      end
      do_cycle("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
